// File: rtl/accum_pkg.sv
// Shared types and width helpers for the windowed accumulator.
package accum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } acc_state_t;

  // Smallest width that holds n samples of w bits summed at full scale.
  function automatic int unsigned sum_width(input int unsigned n, input int unsigned w);
    return $clog2(n * ((32'd1 << w) - 32'd1) + 32'd1);
  endfunction

endpackage

// File: rtl/accum_datapath.sv
// Sum register with load/add enables plus the result capture registers.
module accum_datapath
  import accum_pkg::*;
#(
  parameter int unsigned W_IN  = 3,
  parameter int unsigned W_SUM = 7,
  parameter int unsigned W_CNT = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_load,
  input  logic             i_add,
  input  logic             i_cap,
  input  logic [W_IN-1:0]  i_data,
  input  logic [W_CNT-1:0] i_cnt,
  output logic [W_SUM-1:0] o_res_data,
  output logic [W_CNT-1:0] o_res_cnt
);

  logic [W_SUM-1:0] r_sum;
  logic [W_SUM-1:0] r_res_data;
  logic [W_CNT-1:0] r_res_cnt;
  logic [W_SUM-1:0] w_data_ext;
  logic [W_SUM-1:0] w_sum_nxt;

  assign w_data_ext = W_SUM'(i_data);

  // Capture sees the same next value that the sum register takes, so the
  // result is ready the cycle after the closing beat.
  always_comb begin
    w_sum_nxt = r_sum;
    if (i_load) begin
      w_sum_nxt = w_data_ext;
    end else if (i_add) begin
      w_sum_nxt = r_sum + w_data_ext;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sum      <= '0;
      r_res_data <= '0;
      r_res_cnt  <= '0;
    end else begin
      if (i_load || i_add) begin
        r_sum <= w_sum_nxt;
      end
      if (i_cap) begin
        r_res_data <= w_sum_nxt;
        r_res_cnt  <= i_cnt;
      end
    end
  end

  assign o_res_data = r_res_data;
  assign o_res_cnt  = r_res_cnt;

endmodule

// File: rtl/accum_window_ctrl.sv
// Window sequencer: N_STEPS input beats -> one held result beat.
// Optional early close via s_last when ACC_TLAST_EN is defined.
module accum_window_ctrl
  import accum_pkg::*;
#(
  parameter int unsigned W_IN    = 3,
  parameter int unsigned N_STEPS = 10,
  localparam int unsigned W_SUM  = sum_width(N_STEPS, W_IN),
  localparam int unsigned W_CNT  = $clog2(N_STEPS + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W_IN-1:0]  s_data,
`ifdef ACC_TLAST_EN
  input  logic             s_last,
`endif
  output logic             m_valid,
  input  logic             m_ready,
  output logic [W_SUM-1:0] m_data,
  output logic [W_CNT-1:0] m_count,
  output logic             busy
);

  acc_state_t       r_state;
  acc_state_t       w_state_nxt;
  logic [W_CNT-1:0] r_cnt;
  logic [W_CNT-1:0] w_cnt_nxt;
  logic             w_accept;
  logic             w_last;
  logic             w_load;
  logic             w_add;
  logic             w_close;
  logic             w_cap;

`ifdef ACC_TLAST_EN
  assign w_last = s_last;
`else
  assign w_last = 1'b0;
`endif

  assign s_ready  = (r_state != OUT);
  assign m_valid  = (r_state == OUT);
  assign busy     = (r_state != IDLE);
  assign w_accept = s_valid && s_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load || w_add) begin
        r_cnt <= w_cnt_nxt;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_load) w_state_nxt = w_close ? OUT : ACC;
      ACC:     if (w_add && w_close) w_state_nxt = OUT;
      OUT:     if (m_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath enables and the beat count the closing beat would produce.
  always_comb begin
    w_load    = 1'b0;
    w_add     = 1'b0;
    w_close   = 1'b0;
    w_cnt_nxt = r_cnt;
    case (r_state)
      IDLE: begin
        w_load    = w_accept;
        w_close   = (N_STEPS == 32'd1) || w_last;
        w_cnt_nxt = W_CNT'(1);
      end
      ACC: begin
        w_add     = w_accept;
        w_close   = (r_cnt == W_CNT'(N_STEPS - 32'd1)) || w_last;
        w_cnt_nxt = r_cnt + W_CNT'(1);
      end
      default: ;
    endcase
    w_cap = (w_load || w_add) && w_close;
  end

  accum_datapath #(
    .W_IN  (W_IN),
    .W_SUM (W_SUM),
    .W_CNT (W_CNT)
  ) u_datapath (
    .clk        (clk),
    .rstn       (rstn),
    .i_load     (w_load),
    .i_add      (w_add),
    .i_cap      (w_cap),
    .i_data     (s_data),
    .i_cnt      (w_cnt_nxt),
    .o_res_data (m_data),
    .o_res_cnt  (m_count)
  );

endmodule

// File: tb/tb_accum_window_ctrl.sv
// Self-checking bench for accum_window_ctrl (default N_STEPS=10, W_IN=3).
module tb_accum_window_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       m_ready = 1'b0;
  logic [2:0] s_data = 3'd0;
  logic       s_ready;
  logic       m_valid;
  logic       busy;
  logic [6:0] m_data;
  logic [3:0] m_count;

  accum_window_ctrl dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
`ifdef ACC_TLAST_EN
    .s_last  (s_last),
`endif
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_count (m_count),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sum;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    logic [9:0][2:0] d;
    int unsigned     gap_max;
    logic [31:0]     sum;
  } vec_t;

  exp_t q[$];
  vec_t tbl[4];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hs_last = -1;
  bit   chk_int = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting on DUT (cycle %0d)", name, cyc);
  endtask

  // Result monitor: pops the scoreboard on each output handshake and checks hold.
  logic prev_v = 1'b0;
  logic prev_hs = 1'b0;
  logic [6:0] prev_d = '0;
  exp_t e_mon;
  always @(negedge clk) begin
    if (!rstn) begin
      prev_v  = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_v && !prev_hs) begin
        chk("m_valid_hold", 32'(m_valid), 32'd1);
        chk("m_data_hold", 32'(m_data), 32'(prev_d));
      end
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got m_data=%0d expected no result", m_data);
        end else begin
          e_mon = q.pop_front();
          chk("m_data", 32'(m_data), e_mon.sum);
          chk("m_count", 32'(m_count), e_mon.cnt);
        end
        if (chk_int && hs_last >= 0) chk("result_interval", 32'(cyc - hs_last), 32'd11);
        hs_last = cyc;
      end
      prev_v  = m_valid;
      prev_hs = m_valid && m_ready;
      prev_d  = m_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [2:0] d, input logic last);
    bit done = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (s_ready) done = 1'b1;
      step();
    end
    if (!done) timeout("send_beat");
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic gap(input int unsigned n);
    for (int i = 0; i < int'(n); i++) begin
      @(negedge clk);
      chk("s_ready_gap", 32'(s_ready), 32'd1);
      step();
    end
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) timeout("wait_idle");
    step();
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    wait_idle();
    e.sum = v.sum;
    e.cnt = 32'd10;
    q.push_back(e);
    for (int i = 0; i < 10; i++) begin
      if (i > 0 && v.gap_max > 0) gap($urandom_range(0, v.gap_max));
      send_beat(v.d[i], 1'b0);
    end
    @(negedge clk);
    chk("latency_m_valid", 32'(m_valid), 32'd1);
    chk("s_ready_in_out", 32'(s_ready), 32'd0);
    step();
  endtask

  initial begin
    exp_t e;
    vec_t v;
    logic [31:0] msum;
    int   n;
    int   nwin;
    bit   done;

    for (int i = 0; i < 10; i++) begin
      tbl[0].d[i] = 3'd7;
      tbl[1].d[i] = (i < 8) ? 3'(i) : 3'(i - 8);
      tbl[2].d[i] = 3'd0;
      tbl[3].d[i] = (i % 2 == 0) ? 3'd7 : 3'd0;
    end
    tbl[0].gap_max = 0; tbl[0].sum = 32'd70;
    tbl[1].gap_max = 3; tbl[1].sum = 32'd29;
    tbl[2].gap_max = 2; tbl[2].sum = 32'd0;
    tbl[3].gap_max = 1; tbl[3].sum = 32'd35;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    step();
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_count", 32'(m_count), 32'd0);
    step();

    // Table-driven windows with m_ready held high
    m_ready = 1'b1;
    for (int r = 0; r < 4; r++) run_vec(tbl[r]);

    // Backpressure: result held for 5 cycles
    wait_idle();
    m_ready = 1'b0;
    e.sum = 32'd30;
    e.cnt = 32'd10;
    q.push_back(e);
    for (int i = 0; i < 10; i++) send_beat(3'd3, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_m_valid", 32'(m_valid), 32'd1);
      chk("bp_m_data", 32'(m_data), 32'd30);
      chk("bp_s_ready", 32'(s_ready), 32'd0);
      step();
    end
    m_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp_release_busy", 32'(busy), 32'd0);
    chk("bp_release_s_ready", 32'(s_ready), 32'd1);
    step();

    // Reset mid-window discards the partial sum
    wait_idle();
    for (int i = 0; i < 6; i++) send_beat(3'd7, 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_m_data", 32'(m_data), 32'd0);
    step();
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_s_ready", 32'(s_ready), 32'd1);
    step();
    for (int i = 0; i < 10; i++) v.d[i] = 3'd1;
    v.gap_max = 0;
    v.sum = 32'd10;
    run_vec(v);

`ifdef ACC_TLAST_EN
    // Early close on s_last, then a full window
    wait_idle();
    e.sum = 32'd15;
    e.cnt = 32'd3;
    q.push_back(e);
    send_beat(3'd5, 1'b0);
    send_beat(3'd5, 1'b0);
    send_beat(3'd5, 1'b1);
    @(negedge clk);
    chk("tlast_m_valid", 32'(m_valid), 32'd1);
    step();
    run_vec(tbl[0]);
`endif

    // Back-to-back: continuous valid/ready, random data
    wait_idle();
    chk_int = 1'b1;
    hs_last = -1;
    msum = 0;
    n = 0;
    nwin = 0;
    s_valid = 1'b1;
    for (int c = 0; c < 33; c++) begin
      s_data = 3'($urandom);
      @(negedge clk);
      if (s_ready) begin
        msum = msum + 32'(s_data);
        n++;
        if (n == 10) begin
          e.sum = msum;
          e.cnt = 32'd10;
          q.push_back(e);
          msum = 0;
          n = 0;
          nwin++;
        end
      end
      step();
    end
    s_valid = 1'b0;
    chk("b2b_windows", 32'(nwin), 32'd3);
    wait_idle();
    chk_int = 1'b0;

    // Drain scoreboard
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (q.size() == 0) done = 1'b1;
    end
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
